// File: rtl/lcd_bus_receiver_pkg.sv
// lcd_bus_receiver_pkg
// Shared definitions for the 4-bit character-LCD bus receiver.
// Contents:
//   - bus timing limits in system-clock cycles (50 MHz)
//   - byte FSM state encoding
//   - power-on init nibble sequence and the command codes that matter
//     for cursor tracking
package lcd_bus_receiver_pkg;

   // Timing limits, in Clock cycles.
   localparam int E_MIN_HIGH   = 12;     // enable high time per nibble
   localparam int NIBBLE_GAP   = 50;     // high-nibble fall to low-nibble rise
   localparam int BYTE_GAP     = 2000;   // end of byte to next rise
   localparam int CLEAR_GAP    = 82000;  // same, after clear/home
   localparam int INIT_NIBBLES = 4;

   // Counter widths: the gap counter must hold CLEAR_GAP, and the
   // high-time counter only needs to get past E_MIN_HIGH.
   localparam int GAP_W  = 17;
   localparam int HIGH_W = 8;
   localparam int INIT_W = $clog2(INIT_NIBBLES);

   // Command codes relevant to the address tracker.
   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

   typedef enum logic [1:0] {
      ST_INIT,   // waiting for the power-on init nibbles
      ST_HIGH,   // next nibble is the high half of a byte
      ST_LOW     // next nibble completes the byte
   } rx_state_e;

   // Expected init nibble for a given position in the sequence.
   function automatic logic [3:0] init_nibble(input logic [INIT_W-1:0] idx);
      logic [3:0] val;
      case (idx)
         2'd0:    val = 4'h3;
         2'd1:    val = 4'h3;
         2'd2:    val = 4'h3;
         default: val = 4'h2;
      endcase
      return val;
   endfunction

   // Clear (0x01) and return-home (0x02/0x03, bit0 don't-care) both
   // reset the cursor and need the long recovery gap.
   function automatic logic is_home_cmd(input logic [7:0] cmd);
      return (cmd == CMD_CLEAR) || (cmd[7:1] == CMD_HOME[7:1]);
   endfunction

endpackage

// File: rtl/lcd_bus_receiver_if.sv
// lcd_bus_receiver_if
// Pin bundle between the LCD controller (master) and the display-side
// receiver (slave), plus the decoded results the receiver reports.
//   iLCD_Enabled        enable pin, falling edge latches a nibble
//   iLCD_RegisterSelect 0 = command, 1 = data
//   iLCD_ReadWrite      must be 0 at every latch
//   iLCD_Data           nibble bus
//   oByte / oIsData     last assembled byte and its register select
//   oByteValid          one-cycle strobe when oByte/oIsData update
//   oAddress            tracked DDRAM cursor address
//   oInitDone           init nibble sequence completed
//   oTimingError        sticky timing violation
//   oProtocolError      sticky protocol violation
interface lcd_bus_receiver_if;

   logic       iLCD_Enabled;
   logic       iLCD_RegisterSelect;
   logic       iLCD_ReadWrite;
   logic [3:0] iLCD_Data;

   logic [7:0] oByte;
   logic       oIsData;
   logic       oByteValid;
   logic [6:0] oAddress;
   logic       oInitDone;
   logic       oTimingError;
   logic       oProtocolError;

   modport master (
      output iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data,
      input  oByte, oIsData, oByteValid, oAddress, oInitDone,
             oTimingError, oProtocolError
   );

   modport slave (
      input  iLCD_Enabled, iLCD_RegisterSelect, iLCD_ReadWrite, iLCD_Data,
      output oByte, oIsData, oByteValid, oAddress, oInitDone,
             oTimingError, oProtocolError
   );

endinterface

// File: rtl/lcd_edge_timer.sv
// lcd_edge_timer
// Registers the LCD pins once, detects enable edges and measures the
// enable high time and the low gap between nibbles.
//   Clock, Reset                       system clock, sync active-high reset
//   en_pin, rs_pin, rw_pin, data_pin   raw LCD pins
//   fall, rise                         enable edge pulses (one cycle)
//   rs, rw, nibble                     registered pin copies
//   high_short                         high time below E_MIN_HIGH
//   nibble_gap_short, byte_gap_short,
//   clear_gap_short                    current gap below each limit
module lcd_edge_timer
   import lcd_bus_receiver_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       en_pin,
   input  logic       rs_pin,
   input  logic       rw_pin,
   input  logic [3:0] data_pin,
   output logic       fall,
   output logic       rise,
   output logic       rs,
   output logic       rw,
   output logic [3:0] nibble,
   output logic       high_short,
   output logic       nibble_gap_short,
   output logic       byte_gap_short,
   output logic       clear_gap_short
);

   localparam logic [HIGH_W-1:0] HIGH_MAX = '1;
   localparam logic [GAP_W-1:0]  GAP_MAX  = '1;

   logic              en_q;      // input register copy of enable
   logic              en_d;      // previous en_q, for edge detection
   logic [HIGH_W-1:0] high_cnt;
   logic [GAP_W-1:0]  gap_cnt;

   assign fall = en_d & ~en_q;
   assign rise = en_q & ~en_d;

   // Both counters restart at 1 on their edge so that on the closing edge
   // they hold exactly the number of cycles the pin spent high (or low).
   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         en_q     <= 1'b0;
         en_d     <= 1'b0;
         rs       <= 1'b0;
         rw       <= 1'b0;
         nibble   <= 4'h0;
         high_cnt <= '0;
         // Saturated gap means no gap check can fire before the first
         // falling edge after reset.
         gap_cnt  <= GAP_MAX;
      end else begin
         en_q   <= en_pin;
         en_d   <= en_q;
         rs     <= rs_pin;
         rw     <= rw_pin;
         nibble <= data_pin;

         if (rise)
            high_cnt <= HIGH_W'(1);
         else if (en_q && high_cnt != HIGH_MAX)
            high_cnt <= high_cnt + HIGH_W'(1);

         if (fall)
            gap_cnt <= GAP_W'(1);
         else if (gap_cnt != GAP_MAX)
            gap_cnt <= gap_cnt + GAP_W'(1);
      end
   end

   assign high_short       = high_cnt < HIGH_W'(E_MIN_HIGH);
   assign nibble_gap_short = gap_cnt  < GAP_W'(NIBBLE_GAP);
   assign byte_gap_short   = gap_cnt  < GAP_W'(BYTE_GAP);
   assign clear_gap_short  = gap_cnt  < GAP_W'(CLEAR_GAP);

endmodule

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
// Display-side decoder for the 4-bit character-LCD bus. Checks the init
// nibble sequence, assembles high/low nibble pairs into bytes, tracks the
// DDRAM cursor address and raises sticky timing/protocol error flags.
//   Clock  system clock (50 MHz), rising edge
//   Reset  synchronous, active-high
//   bus    lcd_bus_receiver_if.slave: LCD pins in, decoded results out
module lcd_bus_receiver
   import lcd_bus_receiver_pkg::*;
(
   input logic              Clock,
   input logic              Reset,
   lcd_bus_receiver_if.slave bus
);

   logic       fall, rise, rs, rw;
   logic [3:0] nibble;
   logic       high_short, nibble_gap_short, byte_gap_short, clear_gap_short;

   lcd_edge_timer u_edge_timer (
      .Clock            (Clock),
      .Reset            (Reset),
      .en_pin           (bus.iLCD_Enabled),
      .rs_pin           (bus.iLCD_RegisterSelect),
      .rw_pin           (bus.iLCD_ReadWrite),
      .data_pin         (bus.iLCD_Data),
      .fall             (fall),
      .rise             (rise),
      .rs               (rs),
      .rw               (rw),
      .nibble           (nibble),
      .high_short       (high_short),
      .nibble_gap_short (nibble_gap_short),
      .byte_gap_short   (byte_gap_short),
      .clear_gap_short  (clear_gap_short)
   );

   rx_state_e         state, state_n;
   logic [INIT_W-1:0] init_idx, init_idx_n;
   logic [3:0]        high_nib, high_nib_n;
   logic              high_rs, high_rs_n;
   logic [7:0]        byte_q, byte_n;
   logic              is_data_q, is_data_n;
   logic              valid_q, valid_n;
   logic [6:0]        addr_q, addr_n;
   logic              init_done_q, init_done_n;
   logic              terr_q, terr_n;
   logic              perr_q, perr_n;
   logic              long_gap_q, long_gap_n;   // last byte was clear/home
   logic [7:0]        assembled;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= ST_INIT;
         init_idx    <= '0;
         high_nib    <= 4'h0;
         high_rs     <= 1'b0;
         byte_q      <= 8'h00;
         is_data_q   <= 1'b0;
         valid_q     <= 1'b0;
         addr_q      <= 7'h00;
         init_done_q <= 1'b0;
         terr_q      <= 1'b0;
         perr_q      <= 1'b0;
         long_gap_q  <= 1'b0;
      end else begin
         state       <= state_n;
         init_idx    <= init_idx_n;
         high_nib    <= high_nib_n;
         high_rs     <= high_rs_n;
         byte_q      <= byte_n;
         is_data_q   <= is_data_n;
         valid_q     <= valid_n;
         addr_q      <= addr_n;
         init_done_q <= init_done_n;
         terr_q      <= terr_n;
         perr_q      <= perr_n;
         long_gap_q  <= long_gap_n;
      end
   end

   assign assembled = {high_nib, nibble};

   // NOTE: every variable gets a default at the top of the block so no
   // path through the case statements can infer a latch.
   always_comb begin
      state_n     = state;
      init_idx_n  = init_idx;
      high_nib_n  = high_nib;
      high_rs_n   = high_rs;
      byte_n      = byte_q;
      is_data_n   = is_data_q;
      valid_n     = 1'b0;
      addr_n      = addr_q;
      init_done_n = init_done_q;
      terr_n      = terr_q;
      perr_n      = perr_q;
      long_gap_n  = long_gap_q;

      // Gap checks on the rising edge depend on which half comes next.
      if (rise) begin
         case (state)
            ST_HIGH: if (long_gap_q ? clear_gap_short : byte_gap_short) terr_n = 1'b1;
            ST_LOW:  if (nibble_gap_short) terr_n = 1'b1;
            default: ;
         endcase
      end

      // Timing problems are flagged but never stop the nibble being used.
      if (fall && high_short)
         terr_n = 1'b1;

      if (fall) begin
         if (rw) begin
            // A read cycle is not a write: flag it and leave state alone.
            perr_n = 1'b1;
         end else begin
            case (state)
               ST_INIT: begin
                  if (!rs && nibble == init_nibble(init_idx)) begin
                     if (init_idx == INIT_W'(INIT_NIBBLES - 1)) begin
                        init_done_n = 1'b1;
                        state_n     = ST_HIGH;
                     end else begin
                        init_idx_n = init_idx + INIT_W'(1);
                     end
                  end else begin
                     perr_n = 1'b1;
                  end
               end
               ST_HIGH: begin
                  high_nib_n = nibble;
                  high_rs_n  = rs;
                  state_n    = ST_LOW;
               end
               ST_LOW: begin
                  state_n = ST_HIGH;
                  if (rs != high_rs) begin
                     perr_n = 1'b1;
                  end else begin
                     byte_n     = assembled;
                     is_data_n  = rs;
                     valid_n    = 1'b1;
                     long_gap_n = 1'b0;
                     if (rs)
                        addr_n = addr_q + 7'd1;
                     else if ((assembled & CMD_SET_DDRAM) != 8'h00)
                        addr_n = assembled[6:0];
                     else if (is_home_cmd(assembled)) begin
                        addr_n     = 7'h00;
                        long_gap_n = 1'b1;
                     end
                  end
               end
               default: state_n = ST_INIT;
            endcase
         end
      end
   end

   assign bus.oByte          = byte_q;
   assign bus.oIsData        = is_data_q;
   assign bus.oByteValid     = valid_q;
   assign bus.oAddress       = addr_q;
   assign bus.oInitDone      = init_done_q;
   assign bus.oTimingError   = terr_q;
   assign bus.oProtocolError = perr_q;

endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

Display-side decoder for the 4-bit character-LCD bus that the CPU's LCD controller drives (enable, register-select, read/write and a 4-bit data nibble). It watches those pins, recognises the power-on initialisation nibbles, and reassembles each following high/low nibble pair into a byte. For every byte it reports command or data and tracks the display cursor address, and it flags timing and protocol violations with sticky error bits. It sits beside the LCD controller in the top level as an on-chip checker, and as the bench's display model.

## Interface
- E_MIN_HIGH, 12: minimum cycles enable must stay high per nibble (240 ns at 50 MHz).
- NIBBLE_GAP, 50: minimum cycles from the high-nibble falling edge to the next rising edge.
- BYTE_GAP, 2000: minimum cycles from a byte's last falling edge to the next rising edge.
- CLEAR_GAP, 82000: `BYTE_GAP` replacement after command 0x01, 0x02 or 0x03.
- INIT_NIBBLES, 4: number of single-nibble init writes expected; the values are 0x3, 0x3, 0x3, 0x2.
- Clock  in  1  system clock, 50 MHz; all logic on its rising edge.
- Reset  in  1  synchronous, active-high.
- iLCD_Enabled  in  1  LCD enable pin. The falling edge latches a nibble.
- iLCD_RegisterSelect  in  1  0 = command, 1 = data.
- iLCD_ReadWrite  in  1  must be 0 (write) at every latch.
- iLCD_Data  in  4  nibble bus.
- oByte  out  8  last assembled byte.
- oIsData  out  1  register-select value of `oByte`.
- oByteValid  out  1  one-cycle strobe when `oByte`/`oIsData` update.
- oAddress  out  7  tracked cursor (DDRAM) address.
- oInitDone  out  1  high once the init nibble sequence has completed.
- oTimingError  out  1  sticky timing violation.
- oProtocolError  out  1  sticky protocol violation.

## Operation
- All four inputs are registered once. A falling edge of enable is detected when the registered value is 1 and the current value is 0. RS, RW and the nibble are taken from the registered copies at that point.
- State INIT: each falling edge with RS=0 is compared with the expected init nibble.
  - Match: advance the init index.
  - Mismatch: set `oProtocolError` and hold the index.
  - After `INIT_NIBBLES` matches: set `oInitDone` and go to HIGH.
  - INIT produces no bytes.
- State HIGH: a falling edge latches `nibble[7:4]` and RS, then goes to LOW.
- State LOW: a falling edge latches `nibble[3:0]`, pulses `oByteValid` and goes to HIGH.
  - If RS differs from the high nibble's RS: set `oProtocolError`, discard the byte, no strobe, go to HIGH.
- A falling edge with RW=1 sets `oProtocolError`. The edge is ignored and the state is unchanged.
- Address tracking, applied on each accepted byte:
  - Data byte: `oAddress` += 1, wrapping 0x7F to 0x00.
  - Command with bit7=1: `oAddress` <= byte[6:0].
  - Command 0x01, 0x02 or 0x03: `oAddress` <= 0.
  - Other commands leave the address unchanged.
- Timing checks. Timing violations never discard data.
  - High-time counter: cleared on the rising edge, saturating. A falling edge with count < `E_MIN_HIGH` sets `oTimingError`.
  - Gap counter: cleared on every falling edge, saturating, 17 bits. A rising edge in LOW with gap < `NIBBLE_GAP` sets `oTimingError`.
  - A rising edge in HIGH with gap < `BYTE_GAP` sets `oTimingError`. After a clear/home command the limit is `CLEAR_GAP` instead.
  - Gap checks are inactive until the first falling edge after reset.

## Timing
- Reset values:
  - all outputs 0;
  - state INIT, init index 0;
  - gap counter saturated, high-time counter 0.
- Latency: `oByteValid`, `oByte`, `oIsData` and the updated `oAddress` appear 2 cycles after enable falls on the pin (1 input register, 1 output register).
- `oInitDone` rises with the same 2-cycle latency after the last init nibble.
- `oByteValid` is high for exactly one cycle. `oByte` holds until the next strobe.
- Error flags assert 2 cycles after the offending edge and clear only on Reset.
- Reset mid-byte discards the pending high nibble and returns to INIT.
- Simultaneous protocol and timing violation on one edge: both flags set.
- Enable glitch of one cycle: it is still a nibble and also a timing error.

## Structure
- Shared package holds:
  - state encoding INIT/HIGH/LOW;
  - the init nibble constants 0x3, 0x3, 0x3, 0x2;
  - command constants CLEAR=0x01, HOME=0x02, SET_DDRAM mask 0x80.
- One natural sub-module: `lcd_edge_timer`, covering the input register, edge detection, and the saturating high-time and gap counters with their compare flags.
- The byte FSM and the address tracker stay in the top module.

## Test plan
- Init then byte: nibbles 3, 3, 3, 2, then RS=1 data 0x41, all timings legal. Required: `oInitDone`=1, one strobe with `oByte`=0x41, `oIsData`=1, `oAddress`=1, no errors.
- Addressing: command 0xC5 then data 0x20. Required: `oAddress` 0x45, then 0x46. Then 0x01 followed by a 2000-cycle gap. Required: `oAddress`=0 and `oTimingError`=1.
- Wrap: set address 0x7F, then one data byte. Required: `oAddress`=0x00.
- Short enable pulse: enable high 5 cycles. Required: byte still accepted and `oTimingError`=1.
- RS mismatch: high nibble RS=1, low nibble RS=0. Required: no strobe and `oProtocolError`=1. The next legal byte decodes normally.
- Reset mid-byte: Reset after a high nibble. Required: outputs 0, `oInitDone`=0, and the next nibble is treated as init.
